// File: rtl/multicycle_control.sv
// multicycle_control
//   Main control FSM for the multicycle MIPS datapath. It sequences fetch,
//   decode, execute, memory and writeback for R-type, lw, sw, beq, bne, addi
//   and j. It is a Moore machine, so every control output is decoded from the
//   state register alone. It also counts retired instructions and keeps a
//   sticky flag for unsupported opcodes.
//
// Ports
//   clk, rst_n      clock (rising edge); asynchronous active-low reset
//   Opcode          instr[31:26]; sampled only in DECODE and MEMADR
//   PCWrite         unconditional PC write
//   PCWriteCond     PC write if Zero (beq)
//   PCWriteCondNe   PC write if !Zero (bne)
//   IorD            memory address: 0 = PC, 1 = ALUOut
//   MemRead         memory read enable
//   MemWrite        memory write enable
//   IRWrite         instruction register load
//   MemtoReg        register write data: 0 = ALUOut, 1 = MDR
//   RegDst          destination register: 0 = rt, 1 = rd
//   RegWrite        register file write
//   ALUSrcA         ALU A: 0 = PC, 1 = A
//   ALUSrcB         ALU B: 00 = B, 01 = 4, 10 = imm, 11 = imm << 2
//   PCSource        PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
//   AluOp           to alucontrol: 00 = add, 01 = sub, 10 = use funct
//   State           current state encoding (debug)
//   IllegalOp       sticky unsupported-opcode flag, cleared only by reset
//   InstrCount      retired-instruction count, wraps
module multicycle_control #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Opcode,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             PCWriteCondNe,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [1:0]       AluOp,
  output logic [3:0]       State,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQ     = 4'd8,
    S_BNE     = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12
  } state_e;

  state_e           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  // Next state, sticky illegal flag and retirement counter
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = illegal_q;
    retire    = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_BNE:       state_d = S_BNE;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            // Abort back to FETCH without retiring
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = S_MEMWB;
      S_EXEC:    state_d = S_RTYPEWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_RTYPEWB, S_BEQ, S_BNE, S_ADDIWB, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      // Unreachable encodings recover to FETCH without retiring
      default:   state_d = S_FETCH;
    endcase
    count_d = retire ? count_q + CNT_W'(1) : count_q;
  end

  // Moore output decode
  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNe = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    PCSource      = 2'b00;
    AluOp         = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      S_DECODE:  ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        AluOp   = 2'b10;
      end
      S_RTYPEWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        AluOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_BNE: begin
        ALUSrcA       = 1'b1;
        AluOp         = 2'b01;
        PCWriteCondNe = 1'b1;
        PCSource      = 2'b01;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB:  RegWrite = 1'b1;
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      default: ;
    endcase
  end

  assign State      = state_q;
  assign IllegalOp  = illegal_q;
  assign InstrCount = count_q;

endmodule
